// File: rtl/train_detect.sv
// Track-sensor front end for the crossing semaphore: synchronises and debounces the
// entry/exit sensors, counts trains in the section and drives `train`.
// Optional interrupt support is built when TRAIN_DETECT_IRQ_EN is defined.
module train_detect #(
    parameter int DW = 8,
    parameter int HW = 16,
    parameter int CW = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ctl_wr,
    input  logic        ctl_rd,
    input  logic [1:0]  ctl_addr,
    input  logic [31:0] ctl_wrdata,
    output logic [31:0] ctl_rddata,
    input  logic        sens_in,
    input  logic        sens_out,
`ifdef TRAIN_DETECT_IRQ_EN
    output logic        irq,
`endif
    output logic        train
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OCC  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          en_r;
    logic [DW-1:0] deb_len_r;
    logic [HW-1:0] hold_len_r;
    logic [CW-1:0] cnt_r;
    logic          err_r;
    logic [HW-1:0] timer_r;
    state_t        state_r;
    state_t        state_nxt_s;

    logic [1:0]    sens_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    deb_r;
    logic [1:0]    deb_q_r;
    logic [DW-1:0] dc_r [2];
    logic [1:0]    ev_s;
    logic          ev_in_s;
    logic          ev_out_s;

    logic          wr0_s;
    logic          wr1_s;
    logic          wr2_s;
    logic          clr_s;
    logic          ctl_unused_s;

    assign sens_s       = {sens_out, sens_in};
    assign ev_s         = deb_r & ~deb_q_r;
    assign ev_in_s      = ev_s[0];
    assign ev_out_s     = ev_s[1];
    assign wr0_s        = ctl_wr && (ctl_addr == 2'd0);
    assign wr1_s        = ctl_wr && (ctl_addr == 2'd1);
    assign wr2_s        = ctl_wr && (ctl_addr == 2'd2);
    assign clr_s        = wr0_s && ctl_wrdata[1];
    assign ctl_unused_s = ^{ctl_rd, ctl_wrdata};

    // Configuration registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            en_r       <= 1'b0;
            deb_len_r  <= {DW{1'b0}};
            hold_len_r <= {HW{1'b0}};
        end else begin
            if (wr0_s) en_r       <= ctl_wrdata[0];
            if (wr1_s) deb_len_r  <= ctl_wrdata[DW-1:0];
            if (wr2_s) hold_len_r <= ctl_wrdata[HW-1:0];
        end
    end

    // Two-flop synchronisers and per-sensor debouncers (run regardless of en)
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            deb_q_r <= 2'b00;
            for (int i = 0; i < 2; i++) dc_r[i] <= {DW{1'b0}};
        end else begin
            sync1_r <= sens_s;
            sync2_r <= sync1_r;
            deb_q_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    dc_r[i] <= {DW{1'b0}};
                end else if (dc_r[i] == deb_len_r) begin
                    deb_r[i] <= sync2_r[i];
                    dc_r[i]  <= {DW{1'b0}};
                end else begin
                    dc_r[i] <= dc_r[i] + DW'(1);
                end
            end
        end
    end

    // Occupancy counter and sticky error flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_r <= {CW{1'b0}};
            err_r <= 1'b0;
        end else if (clr_s) begin
            cnt_r <= {CW{1'b0}};
            err_r <= 1'b0;
        end else if (!en_r) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            case ({ev_in_s, ev_out_s})
                2'b10: begin
                    if (cnt_r == CNT_MAX) err_r <= 1'b1;
                    else                  cnt_r <= cnt_r + CW'(1);
                end
                2'b01: begin
                    if (cnt_r == CW'(0)) err_r <= 1'b1;
                    else                 cnt_r <= cnt_r - CW'(1);
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (!en_r) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ev_in_s) state_nxt_s = ST_OCC;
                    else         state_nxt_s = ST_IDLE;
                end
                ST_OCC: begin
                    if ((cnt_r == CW'(0)) && !ev_in_s) state_nxt_s = ST_HOLD;
                    else                               state_nxt_s = ST_OCC;
                end
                ST_HOLD: begin
                    if (ev_in_s)                 state_nxt_s = ST_OCC;
                    else if (timer_r == HW'(0))  state_nxt_s = ST_IDLE;
                    else                         state_nxt_s = ST_HOLD;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Hold-off timer: loaded on entry to HOLD, so hold_len edits affect the next hold only
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            timer_r <= {HW{1'b0}};
        end else if (!en_r) begin
            timer_r <= {HW{1'b0}};
        end else if ((state_r == ST_OCC) && (state_nxt_s == ST_HOLD)) begin
            timer_r <= hold_len_r;
        end else if ((state_r == ST_HOLD) && !ev_in_s && (timer_r != HW'(0))) begin
            timer_r <= timer_r - HW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // FSM outputs, decoded from the state register only
    always_comb begin
        train = (state_r != ST_IDLE);
    end

`ifdef TRAIN_DETECT_IRQ_EN
    logic irq_pend_r;

    // Interrupt pending flag; a new set wins over a clear in the same cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            irq_pend_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_OCC)) begin
            irq_pend_r <= 1'b1;
        end else if (ctl_wr && (ctl_addr == 2'd3) && ctl_wrdata[4]) begin
            irq_pend_r <= 1'b0;
        end else begin
            irq_pend_r <= irq_pend_r;
        end
    end

    assign irq = irq_pend_r & en_r;
`endif

    // Combinational register read mux
    always_comb begin
        ctl_rddata = 32'd0;
        case (ctl_addr)
            2'd0: ctl_rddata[0]      = en_r;
            2'd1: ctl_rddata[DW-1:0] = deb_len_r;
            2'd2: ctl_rddata[HW-1:0] = hold_len_r;
            2'd3: begin
                ctl_rddata[0]    = train;
                ctl_rddata[2:1]  = state_r;
                ctl_rddata[3]    = err_r;
                ctl_rddata[15:8] = 8'(cnt_r);
`ifdef TRAIN_DETECT_IRQ_EN
                ctl_rddata[4]    = irq_pend_r;
`endif
            end
            default: ctl_rddata = 32'd0;
        endcase
    end

endmodule

// File: doc/train_detect.md
Name: train_detect

Overview:
- Upstream stage of the crossing semaphore controller; produces its `train` input.
- Synchronises and debounces two raw track sensors: entry (approach) and exit.
- Counts trains inside the crossing section and asserts `train` while the section is occupied, plus a programmable hold-off time after it clears.
- Configured and monitored over the same 32-bit control-slave style as the semaphore block.

Parameters:
DW  8   width of debounce-length register
HW  16  width of hold-off timer register
CW  4   width of occupancy counter (legal 1..8)

Ports:
clk         in   1   clock
clrn        in   1   asynchronous active-low reset
ctl_wr      in   1   control write strobe
ctl_rd      in   1   control read strobe (informational; reads are combinational)
ctl_addr    in   2   control register address
ctl_wrdata  in   32  control write data
ctl_rddata  out  32  control read data
sens_in     in   1   raw entry sensor, asynchronous, active-high
sens_out    in   1   raw exit sensor, asynchronous, active-high
train       out  1   section occupied/hold, to semaphore `train`

Behaviour:
- Reset: clk and clrn as above; clrn asynchronous, active-low. Reset values: en=0, deb_len=0, hold_len=0, cnt=0, err=0, state=IDLE, timer=0, all sync/debounce flops 0, train=0.
- Registers (write on ctl_wr at posedge clk):
  - addr0: bit0 en (R/W); bit1 clr (write-only, self-clearing; clears cnt and err in the same cycle).
  - addr1: deb_len[DW-1:0].
  - addr2: hold_len[HW-1:0].
  - addr3: read-only status: bit0 train, bits[2:1] state (00 IDLE, 01 OCC, 10 HOLD), bit3 err, bits[15:8] cnt zero-extended.
- Reads: combinational from ctl_addr. Unused bits read 0.
- Sync: each sensor passes through 2 flops (s).
- Debounce, per sensor, with debounced value d and counter dc:
  - if s==d, dc<=0;
  - else if dc==deb_len, d<=s and dc<=0;
  - else dc<=dc+1.
  - d therefore follows a stable level deb_len+1 cycles after s changes.
  - Pulses shorter than deb_len+1 cycles after sync are ignored.
- Event: ev = d & ~d_q (d_q is d delayed one cycle); a one-cycle pulse per debounced rising edge.
- Counter:
  - ev_in alone: cnt+1, saturating at 2^CW-1 (saturation sets err).
  - ev_out alone: cnt-1; if cnt==0 it stays 0 and err is set.
  - Both events in the same cycle: cnt unchanged.
  - clr has priority over events.
- FSM:
  - IDLE: on ev_in go to OCC.
  - OCC: if cnt==0 and !ev_in, go to HOLD and load timer<=hold_len.
  - HOLD: ev_in goes to OCC. Otherwise, timer==0 goes to IDLE; else timer-1.
- train = (state != IDLE), decoded from the state register.
- Latency:
  - Raw sens_in rise to train=1 is 4+deb_len cycles from IDLE.
  - Exit event at edge E: HOLD at E+1, IDLE at E+2+hold_len.
- en=0: FSM held in IDLE, cnt and timer held at 0, train=0. Debouncers keep running, so re-enabling does not see a stale edge. err is retained.
- Register writes while running:
  - A deb_len change applies on the next comparison.
  - A hold_len change applies on the next HOLD entry.
- Mid-operation reset returns everything to the reset values immediately.

Optional Feature:
TRAIN_DETECT_IRQ_EN
- Defined:
  - Adds output port irq (1 bit).
  - irq_pend is set on each IDLE->OCC transition and is readable at addr3 bit4.
  - Writing addr3 with bit4=1 clears it; a set in the same cycle wins.
  - irq = irq_pend & en. Reset value 0.
- Undefined: no irq port; addr3 bit4 reads 0; writes to addr3 are ignored.

Test Plan:
- Basic pass: en=1, deb_len=0, hold_len=3. sens_in pulse 10 cycles, then sens_out pulse 10 cycles. Required: train rises 4 cycles after the sens_in rise; cnt goes 1 then 0; train falls 5 cycles after the exit event pulse; state goes IDLE→OCC→HOLD→IDLE.
- Debounce: deb_len=5. 5-cycle sens_in glitch produces no event and train stays 0. 6-cycle stable high gives train=1 at 9 cycles after the rise.
- Re-entry in HOLD: hold_len=100. Entry event while in HOLD returns state to OCC, train stays 1 throughout, cnt=1.
- Counter limits: CW=4. 16 entry events leave cnt=15 with err=1. Exit event with cnt=0 leaves cnt=0 with err=1. Write addr0=0x3 gives cnt=0, err=0, en=1.
- Simultaneous events and disable: entry and exit events in the same cycle leave cnt unchanged. en=0 while OCC gives train=0, state=IDLE, cnt=0 on the next cycle.
- Async reset: clrn low mid-HOLD clears train and all registers without a clock edge. With TRAIN_DETECT_IRQ_EN, irq=1 after the first entry and clears on writing addr3=0x10.
